// File: rtl/alu_arbiter.sv
// Two-requester front end for a single shared external ALU.
// Round-robin grant, operand capture, one-cycle execute and a held response.
module alu_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             r0_valid_i,
  input  logic             r1_valid_i,
  output logic             r0_ready_o,
  output logic             r1_ready_o,
  input  logic [3:0]       r0_op_i,
  input  logic [3:0]       r1_op_i,
  input  logic [WIDTH-1:0] r0_a_i,
  input  logic [WIDTH-1:0] r0_b_i,
  input  logic [WIDTH-1:0] r1_a_i,
  input  logic [WIDTH-1:0] r1_b_i,
  output logic             r0_rsp_valid_o,
  output logic             r1_rsp_valid_o,
  input  logic             r0_rsp_ready_i,
  input  logic             r1_rsp_ready_i,
  output logic [WIDTH-1:0] rsp_result_o,
  output logic             rsp_err_o,
  output logic [WIDTH-1:0] alu_a_o,
  output logic [WIDTH-1:0] alu_b_o,
  output logic [3:0]       alu_ctrl_o,
  input  logic [WIDTH-1:0] alu_result_i
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             ptr_q, ptr_d;
  logic             gnt_q, gnt_d;
  logic [3:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             err_q, err_d;

  logic [1:0]       req_valid;
  logic [1:0]       req_rsp_ready;
  logic [3:0]       req_op [2];
  logic [WIDTH-1:0] req_a [2];
  logic [WIDTH-1:0] req_b [2];
  logic [1:0]       ready_vec;
  logic [1:0]       rsp_valid_vec;
  logic             win;

  assign req_valid     = {r1_valid_i, r0_valid_i};
  assign req_rsp_ready = {r1_rsp_ready_i, r0_rsp_ready_i};
  assign req_op[0]     = r0_op_i;
  assign req_op[1]     = r1_op_i;
  assign req_a[0]      = r0_a_i;
  assign req_a[1]      = r1_a_i;
  assign req_b[0]      = r0_b_i;
  assign req_b[1]      = r1_b_i;

  function automatic logic op_is_legal(input logic [3:0] op);
    return (op <= 4'd8) || (op == 4'd10);
  endfunction

  // With a single requester pending it wins outright; the pointer only breaks ties.
  assign win = (req_valid == 2'b11) ? ptr_q : req_valid[1];

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    gnt_d         = gnt_q;
    op_d          = op_q;
    a_d           = a_q;
    b_d           = b_q;
    result_d      = result_q;
    err_d         = err_q;
    ready_vec     = 2'b00;
    rsp_valid_vec = 2'b00;
    case (state_q)
      IDLE: begin
        if (|req_valid) begin
          ready_vec[win] = 1'b1;
          gnt_d          = win;
          op_d           = req_op[win];
          a_d            = req_a[win];
          b_d            = req_b[win];
          if (op_is_legal(req_op[win])) begin
            state_d = EXEC;
          end else begin
            state_d  = RESP;
            result_d = '0;
            err_d    = 1'b1;
          end
        end
      end
      EXEC: begin
        result_d = alu_result_i;
        err_d    = 1'b0;
        state_d  = RESP;
      end
      RESP: begin
        rsp_valid_vec[gnt_q] = 1'b1;
        if (req_rsp_ready[gnt_q]) begin
          state_d = IDLE;
          ptr_d   = ~gnt_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      ptr_q    <= 1'b0;
      gnt_q    <= 1'b0;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      gnt_q    <= gnt_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      err_q    <= err_d;
    end
  end

  // Ready is combinational from the request lines, so it must be masked while reset is held.
  assign r0_ready_o     = ready_vec[0] & ~rst_i;
  assign r1_ready_o     = ready_vec[1] & ~rst_i;
  assign r0_rsp_valid_o = rsp_valid_vec[0];
  assign r1_rsp_valid_o = rsp_valid_vec[1];
  assign rsp_result_o   = result_q;
  assign rsp_err_o      = err_q;
  assign alu_a_o        = a_q;
  assign alu_b_o        = b_q;
  assign alu_ctrl_o     = op_q;

endmodule
